// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: single stall/flush source for the 5-stage RISC-V pipeline.
// Combines load-use detection, taken-branch flush and a data-memory wait FSM
// with a timeout watchdog.
// Optional feature macro: HAZARD_STATS_EN adds three 32-bit saturating event
// counters (load-use bubbles, flushes, stall cycles) and their output ports.
`timescale 1ns/1ps
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] IFID_rs1_i,
  input  logic [4:0] IFID_rs2_i,
  input  logic [4:0] IDEX_rd_i,
  input  logic       IDEX_MemRead_i,
  input  logic       Branch_taken_i,
  input  logic       EXMEM_MemRead_i,
  input  logic       EXMEM_MemWrite_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       stall_o,
  output logic       NoOp_o,
  output logic       PCWrite_o,
  output logic       IFIDWrite_o,
  output logic       Flush_o,
  output logic       mem_err_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stat_lu_o,
  output logic [31:0] stat_flush_o,
  output logic [31:0] stat_wait_o
`endif
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic             acc;
  logic             req_raw;
  logic             stall_raw;
  logic             lu;

  assign acc = EXMEM_MemRead_i | EXMEM_MemWrite_i;

  // Load-use: EX holds a load whose destination is a source of the ID instruction.
  assign lu = IDEX_MemRead_i & (IDEX_rd_i != 5'd0) &
              ((IDEX_rd_i == IFID_rs1_i) | (IDEX_rd_i == IFID_rs2_i));

  // Memory wait FSM: next state, wait counter, watchdog, raw request/stall.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    req_raw    = 1'b0;
    stall_raw  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_raw = acc;
        if (acc && !mem_ack_i) begin
          stall_raw  = 1'b1;
          state_next = MEM_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        req_raw = 1'b1;
        if (mem_ack_i) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          // Watchdog: abandon the access, release the pipeline, latch the error.
          err_next   = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          stall_raw = 1'b1;
          cnt_next  = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM state, wait counter and sticky error register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  assign mem_err_o = err_reg;

  // Output priority: memory stall > load-use bubble > branch flush > run; reset forces a bubble.
  always_comb begin
    mem_req_o   = 1'b0;
    stall_o     = 1'b0;
    NoOp_o      = 1'b1;
    PCWrite_o   = 1'b0;
    IFIDWrite_o = 1'b0;
    Flush_o     = 1'b0;
    if (rst_i) begin
      mem_req_o = req_raw;
      stall_o   = stall_raw;
      NoOp_o    = 1'b0;
      if (stall_raw) begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
      end else if (lu) begin
        NoOp_o = 1'b1;
      end else if (Branch_taken_i) begin
        Flush_o     = 1'b1;
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
      end else begin
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [2:0]  stat_inc;
  logic [31:0] stat_val [3];

  // Event strobes: 0 = load-use bubble, 1 = flush, 2 = stall cycle.
  assign stat_inc = {stall_o, Flush_o, NoOp_o & rst_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [31:0] cnt_reg;

    // Saturating event counter; holds at all-ones.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end

    assign stat_val[gi] = cnt_reg;
  end

  assign stat_lu_o    = stat_val[0];
  assign stat_flush_o = stat_val[1];
  assign stat_wait_o  = stat_val[2];
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (TIMEOUT = 4): reset values,
// a vector table of combinational cases, hand sequences for the multi-cycle
// memory cases, and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

  localparam int TO = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] IFID_rs1_i, IFID_rs2_i, IDEX_rd_i;
  logic       IDEX_MemRead_i, Branch_taken_i;
  logic       EXMEM_MemRead_i, EXMEM_MemWrite_i, mem_ack_i;
  logic       mem_req_o, stall_o, NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, mem_err_o;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_lu_o, stat_flush_o, stat_wait_o;
`endif

  hazard_stall_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .IFID_rs1_i      (IFID_rs1_i),
    .IFID_rs2_i      (IFID_rs2_i),
    .IDEX_rd_i       (IDEX_rd_i),
    .IDEX_MemRead_i  (IDEX_MemRead_i),
    .Branch_taken_i  (Branch_taken_i),
    .EXMEM_MemRead_i (EXMEM_MemRead_i),
    .EXMEM_MemWrite_i(EXMEM_MemWrite_i),
    .mem_ack_i       (mem_ack_i),
    .mem_req_o       (mem_req_o),
    .stall_o         (stall_o),
    .NoOp_o          (NoOp_o),
    .PCWrite_o       (PCWrite_o),
    .IFIDWrite_o     (IFIDWrite_o),
    .Flush_o         (Flush_o),
    .mem_err_o       (mem_err_o)
`ifdef HAZARD_STATS_EN
    ,
    .stat_lu_o       (stat_lu_o),
    .stat_flush_o    (stat_flush_o),
    .stat_wait_o     (stat_wait_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Output bundle order: {req, stall, noop, pcwrite, ifidwrite, flush}
  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, exrd, exwr, ack;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {mem_req_o, stall_o, NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o};
  endfunction

  task automatic idle_in();
    IFID_rs1_i = 0; IFID_rs2_i = 0; IDEX_rd_i = 0;
    IDEX_MemRead_i = 0; Branch_taken_i = 0;
    EXMEM_MemRead_i = 0; EXMEM_MemWrite_i = 0; mem_ack_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: expected outputs from the priority rules, given the stall decision.
  function automatic logic [5:0] ref_outs(input logic req, input logic stall,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd, input logic mr, input logic br);
    logic lu_h;
    lu_h = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    if (stall)     return {req, 1'b1, 4'b0000};
    else if (lu_h) return {req, 1'b0, 4'b1000};
    else if (br)   return {req, 1'b0, 4'b0111};
    else           return {req, 1'b0, 4'b0110};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int req_n, stall_n;
    bit m_busy, m_err;
    int m_waited;

    vecs[0] = '{"lu_rs2",     5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 0, 6'b001000};
    vecs[1] = '{"lu_rd0",     5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 6'b000110};
    vecs[2] = '{"lu_over_br", 5'd5, 5'd2, 5'd5, 1, 1, 0, 0, 0, 6'b001000};
    vecs[3] = '{"br_only",    5'd5, 5'd2, 5'd5, 0, 1, 0, 0, 0, 6'b000111};
    vecs[4] = '{"no_match",   5'd3, 5'd4, 5'd7, 1, 0, 0, 0, 0, 6'b000110};
    vecs[5] = '{"zw_load_lu", 5'd9, 5'd1, 5'd9, 1, 0, 1, 0, 1, 6'b101000};
    vecs[6] = '{"zw_store_br",5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1, 6'b100111};
    vecs[7] = '{"ack_no_acc", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 6'b000110};

    // ---- reset values, even with a load-use and an access pending ----
    idle_in();
    rst_i = 1'b0;
    EXMEM_MemRead_i = 1; IDEX_MemRead_i = 1; IDEX_rd_i = 5; IFID_rs1_i = 5;
    #3;
    chk("reset_outs", outs(), 6'b001000);
    chk("reset_err", mem_err_o, 0);
    $display("reset: outs=%b err=%b", outs(), mem_err_o);
    repeat (2) @(posedge clk_i);
    #1;
    idle_in();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_reset_run", outs(), 6'b000110);
    tick();

    // ---- load-use: one bubble, then rd = 0 gives no stall ----
    IDEX_MemRead_i = 1; IDEX_rd_i = 5; IFID_rs1_i = 1; IFID_rs2_i = 5;
    @(negedge clk_i); chk("lu_bubble", outs(), 6'b001000);
    $display("lu rd=5: outs=%b", outs());
    tick();
    IDEX_MemRead_i = 0;
    @(negedge clk_i); chk("lu_release", outs(), 6'b000110);
    tick();
    IDEX_MemRead_i = 1; IDEX_rd_i = 0; IFID_rs1_i = 0; IFID_rs2_i = 0;
    @(negedge clk_i); chk("lu_rd0_seq", outs(), 6'b000110);
    $display("lu rd=0: outs=%b", outs());
    tick();

    // ---- load-use with taken branch, then branch alone ----
    IDEX_MemRead_i = 1; IDEX_rd_i = 5; IFID_rs1_i = 5; Branch_taken_i = 1;
    @(negedge clk_i); chk("lu_br_same", outs(), 6'b001000);
    tick();
    IDEX_MemRead_i = 0;
    @(negedge clk_i); chk("br_next", outs(), 6'b000111);
    $display("lu+br then br: outs=%b", outs());
    tick();
    idle_in();

    // ---- load with ack 3 cycles after request ----
    req_n = 0; stall_n = 0;
    EXMEM_MemRead_i = 1;
    for (int i = 0; i < 7; i++) begin
      mem_ack_i = (i == 3);
      if (i >= 4) EXMEM_MemRead_i = 0;
      @(negedge clk_i);
      req_n += int'(mem_req_o);
      stall_n += int'(stall_o);
      if (i == 3) chk("ack3_release", outs(), 6'b100110);
      tick();
    end
    chk("ack3_req_cycles", req_n, 4);
    chk("ack3_stall_cycles", stall_n, 3);
    $display("ack after 3: req=%0d stall=%0d", req_n, stall_n);
    idle_in();

    // ---- zero-wait access ----
    EXMEM_MemRead_i = 1; mem_ack_i = 1;
    @(negedge clk_i); chk("zw_outs", outs(), 6'b100110);
    tick();
    idle_in();
    @(negedge clk_i); chk("zw_idle", outs(), 6'b000110);
    $display("zero-wait: done");
    tick();

`ifdef HAZARD_STATS_EN
    chk("stat_lu", stat_lu_o, 2);
    chk("stat_flush", stat_flush_o, 1);
    chk("stat_wait", stat_wait_o, 3);
    $display("stats: lu=%0d flush=%0d wait=%0d", stat_lu_o, stat_flush_o, stat_wait_o);
`endif

    // ---- combinational vector table (all keep the FSM in IDLE) ----
    foreach (vecs[k]) begin
      IFID_rs1_i = vecs[k].rs1; IFID_rs2_i = vecs[k].rs2; IDEX_rd_i = vecs[k].rd;
      IDEX_MemRead_i = vecs[k].mr; Branch_taken_i = vecs[k].br;
      EXMEM_MemRead_i = vecs[k].exrd; EXMEM_MemWrite_i = vecs[k].exwr;
      mem_ack_i = vecs[k].ack;
      @(negedge clk_i);
      chk(vecs[k].name, outs(), vecs[k].exp);
      $display("vec %s: outs=%b", vecs[k].name, outs());
      tick();
    end
    idle_in();

    // ---- watchdog: no ack ----
    stall_n = 0;
    EXMEM_MemWrite_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      stall_n += int'(stall_o);
      if (i == 4) chk("to_giveup", outs(), 6'b100110);
      tick();
    end
    EXMEM_MemWrite_i = 0;
    chk("to_stall_cycles", stall_n, TO);
    @(negedge clk_i);
    chk("to_err", mem_err_o, 1);
    chk("to_idle", outs(), 6'b000110);
    tick(); tick();
    @(negedge clk_i);
    chk("to_err_sticky", mem_err_o, 1);
    $display("timeout: stall=%0d err=%b", stall_n, mem_err_o);
    tick();

    // ---- reset in the second MEM_WAIT cycle ----
    EXMEM_MemRead_i = 1;
    tick(); tick();
    #2;
    rst_i = 1'b0;
    #1;
    chk("rst_mid_outs", outs(), 6'b001000);
    chk("rst_mid_err", mem_err_o, 0);
    $display("reset in wait: outs=%b err=%b", outs(), mem_err_o);
    tick();
    rst_i = 1'b1;
    @(negedge clk_i); chk("rst_new_access", outs(), 6'b110000);
    tick();
    mem_ack_i = 1;
    @(negedge clk_i); chk("rst_new_ack", outs(), 6'b100110);
    tick();
    idle_in();
    @(negedge clk_i); chk("rst_new_idle", outs(), 6'b000110);
    tick();

    // ---- randomized run against the behavioural model ----
    m_busy = 0; m_waited = 0; m_err = 0;
    for (int i = 0; i < 300; i++) begin
      logic access, give_up, e_stall;
      logic [5:0] e_outs;
      IFID_rs1_i = 5'($urandom_range(0, 3));
      IFID_rs2_i = 5'($urandom_range(0, 3));
      IDEX_rd_i = 5'($urandom_range(0, 3));
      IDEX_MemRead_i = ($urandom_range(0, 1) == 1);
      Branch_taken_i = ($urandom_range(0, 2) == 0);
      EXMEM_MemRead_i = ($urandom_range(0, 4) == 0);
      EXMEM_MemWrite_i = ($urandom_range(0, 5) == 0);
      mem_ack_i = ($urandom_range(0, 3) == 0);
      access = m_busy || EXMEM_MemRead_i || EXMEM_MemWrite_i;
      give_up = m_busy && !mem_ack_i && (m_waited >= TO);
      e_stall = access && !mem_ack_i && !give_up;
      e_outs = ref_outs(access, e_stall, IFID_rs1_i, IFID_rs2_i, IDEX_rd_i,
                        IDEX_MemRead_i, Branch_taken_i);
      @(negedge clk_i);
      chk("rand_outs", outs(), e_outs);
      chk("rand_err", mem_err_o, m_err);
      $display("rand %0d: outs=%b exp=%b err=%b", i, outs(), e_outs, mem_err_o);
      if (e_stall) begin
        m_busy = 1; m_waited++;
      end else begin
        if (give_up) m_err = 1;
        m_busy = 0; m_waited = 0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It combines load-use hazard detection, branch flush generation and a data-memory wait FSM with a timeout watchdog into one stall/flush source. It drives `NoOp_i` of the decoder control unit, the PC and IF/ID write enables, the IF/ID flush, and a global freeze for variable-latency data memory.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of consecutive MEM_WAIT cycles before the watchdog fires.
- `CNT_W`, default 8: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `IFID_rs1_i`, in, 5: rs1 field of the instruction in ID.
- `IFID_rs2_i`, in, 5: rs2 field of the instruction in ID.
- `IDEX_rd_i`, in, 5: rd of the instruction in EX.
- `IDEX_MemRead_i`, in, 1: the instruction in EX is a load.
- `Branch_taken_i`, in, 1: a branch resolved taken in ID.
- `EXMEM_MemRead_i`, in, 1: the MEM-stage instruction reads data memory.
- `EXMEM_MemWrite_i`, in, 1: the MEM-stage instruction writes data memory.
- `mem_ack_i`, in, 1: data memory completes the current access.
- `mem_req_o`, out, 1: data-memory access request.
- `stall_o`, out, 1: freeze every pipeline register and the PC.
- `NoOp_o`, out, 1: to the control unit; zeroes all control outputs (bubble).
- `PCWrite_o`, out, 1: PC update enable.
- `IFIDWrite_o`, out, 1: IF/ID write enable.
- `Flush_o`, out, 1: clear IF/ID.
- `mem_err_o`, out, 1: sticky watchdog error flag.

## Operation
- Memory FSM has two states, IDLE and MEM_WAIT. Define `acc = EXMEM_MemRead_i | EXMEM_MemWrite_i`.
- IDLE:
  - `mem_req_o = acc`.
  - If `acc & mem_ack_i`: stay in IDLE; zero-wait access, `stall_o = 0`.
  - If `acc & ~mem_ack_i`: `stall_o = 1`; go to MEM_WAIT; wait counter loads 1.
- MEM_WAIT:
  - `mem_req_o = 1`.
  - `stall_o = ~mem_ack_i`.
  - On `mem_ack_i`: go to IDLE; counter clears.
  - Otherwise the counter increments. When the counter equals TIMEOUT and there is no ack: set `mem_err_o`, force IDLE and clear the counter. `stall_o` is 0 in that cycle, so the access is abandoned.
- `mem_err_o` clears only on reset.
- Load-use hazard: `lu = IDEX_MemRead_i & (IDEX_rd_i != 0) & (IDEX_rd_i == IFID_rs1_i | IDEX_rd_i == IFID_rs2_i)`.
- Priority of the combinational outputs, highest first:
  1. `stall_o = 1`: `PCWrite_o = 0`, `IFIDWrite_o = 0`, `NoOp_o = 0`, `Flush_o = 0`. Everything is held; no bubble.
  2. `lu`: `NoOp_o = 1`, `PCWrite_o = 0`, `IFIDWrite_o = 0`, `Flush_o = 0`. A taken branch in the same cycle is suppressed and re-resolves next cycle.
  3. `Branch_taken_i`: `Flush_o = 1`, `PCWrite_o = 1`, `IFIDWrite_o = 1`, `NoOp_o = 0`.
  4. Otherwise: `PCWrite_o = 1`, `IFIDWrite_o = 1`, all others 0.

## Timing
- Reset (`rst_i` = 0), asynchronous:
  - State goes to IDLE; counter, `mem_err_o` and statistics counters go to 0.
  - While reset is held, outputs are forced to `mem_req_o = 0`, `stall_o = 0`, `NoOp_o = 1`, `PCWrite_o = 0`, `IFIDWrite_o = 0`, `Flush_o = 0`.
- Reset during MEM_WAIT abandons the access immediately; there is no ack handshake.
- Hazard outputs are combinational, with zero latency from their inputs.
- Load-use inserts exactly 1 bubble cycle.
- A memory access with ack arriving N cycles after the request costs N stall cycles.
- An ack arriving in IDLE while `acc = 0` is ignored.
- Counter width is `CNT_W`; no wrap is possible because the watchdog fires at TIMEOUT.

## Configuration
- Macro `HAZARD_STATS_EN`.
- Defined: adds three 32-bit saturating counters, all reset to 0, plus output ports `stat_lu_o`, `stat_flush_o` and `stat_wait_o` (32 bits each).
  - `stat_lu_o` increments each cycle `lu` takes effect, i.e. `NoOp_o = 1` outside reset.
  - `stat_flush_o` increments each cycle `Flush_o = 1`.
  - `stat_wait_o` increments each cycle `stall_o = 1`.
  - Each counter holds at 0xFFFFFFFF.
- Undefined: the counters and ports are absent; all other behaviour is identical.

## Test plan
- Load-use: EX holds a load with rd = 5 and ID rs2 = 5, no memory access. Expect `NoOp_o = 1` and `PCWrite_o = IFIDWrite_o = 0` for exactly 1 cycle. Repeat with rd = 0: no stall.
- Load-use plus taken branch in the same cycle: expect `NoOp_o = 1`, `Flush_o = 0`. Next cycle, with `lu` clear and the branch still taken: `Flush_o = 1`.
- Load access with ack 3 cycles after the request: `mem_req_o = 1` for 4 cycles, `stall_o = 1` for 3 cycles, back to IDLE. With ack in the same cycle: `stall_o` never asserts.
- No ack with TIMEOUT = 4: `stall_o = 1` for 4 cycles, then `mem_err_o = 1` stays set and the FSM is in IDLE.
- Assert `rst_i` low in the second MEM_WAIT cycle: outputs immediately take their reset values; after release, a new access proceeds normally.
- With `HAZARD_STATS_EN`: run the first three scenarios and expect `stat_lu_o = 2`, `stat_flush_o = 1`, `stat_wait_o = 3`.
